// File: rtl/axil_cmd_master_if.sv
// AXI4-Lite master/slave bus bundle used by axil_cmd_master.
// Width macros default to a 32-bit AXI4-Lite bus unless the build defines them.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_STROBE_WIDTH
`define AXI_STROBE_WIDTH 4
`endif
`ifndef AXI_RESP_WIDTH
`define AXI_RESP_WIDTH 2
`endif
`ifndef AXI_RESP_OKAY
`define AXI_RESP_OKAY 2'b00
`endif
`ifndef AXI_RESP_SLVERR
`define AXI_RESP_SLVERR 2'b10
`endif

interface axil_cmd_master_if;
  logic                          awvalid;
  logic                          awready;
  logic [`AXI_ADDR_WIDTH-1:0]    awaddr;
  logic [2:0]                    awprot;
  logic                          wvalid;
  logic                          wready;
  logic [`AXI_DATA_WIDTH-1:0]    wdata;
  logic [`AXI_STROBE_WIDTH-1:0]  wstrb;
  logic                          bvalid;
  logic                          bready;
  logic [`AXI_RESP_WIDTH-1:0]    bresp;
  logic                          arvalid;
  logic                          arready;
  logic [`AXI_ADDR_WIDTH-1:0]    araddr;
  logic [2:0]                    arprot;
  logic                          rvalid;
  logic                          rready;
  logic [`AXI_DATA_WIDTH-1:0]    rdata;
  logic [`AXI_RESP_WIDTH-1:0]    rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axil_cmd_master.sv
// Single-outstanding command-to-AXI4-Lite master with registered handshakes.
// Define AXIL_CMD_MASTER_TIMEOUT_EN to abort transactions after TIMEOUT_CYCLES.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_STROBE_WIDTH
`define AXI_STROBE_WIDTH 4
`endif
`ifndef AXI_RESP_WIDTH
`define AXI_RESP_WIDTH 2
`endif
`ifndef AXI_RESP_OKAY
`define AXI_RESP_OKAY 2'b00
`endif
`ifndef AXI_RESP_SLVERR
`define AXI_RESP_SLVERR 2'b10
`endif

module axil_cmd_master #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                          CLK,
  input  logic                          RSTn,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [`AXI_ADDR_WIDTH-1:0]    cmd_addr,
  input  logic [`AXI_DATA_WIDTH-1:0]    cmd_wdata,
  input  logic [`AXI_STROBE_WIDTH-1:0]  cmd_wstrb,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [`AXI_DATA_WIDTH-1:0]    rsp_rdata,
  output logic [`AXI_RESP_WIDTH-1:0]    rsp_resp,
  output logic                          rsp_timeout,
  output logic                          busy,
  axil_cmd_master_if.master             m_axi
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_WRESP = 3'd2,
    ST_RADDR = 3'd3,
    ST_RDATA = 3'd4,
    ST_RESP  = 3'd5
  } state_t;

  state_t                         state_r;
  logic                           cmd_ready_r;
  logic                           awvalid_r;
  logic                           wvalid_r;
  logic                           bready_r;
  logic                           arvalid_r;
  logic                           rready_r;
  logic                           aw_done_r;
  logic                           w_done_r;
  logic                           rsp_valid_r;
  logic                           busy_r;
  logic [`AXI_ADDR_WIDTH-1:0]     addr_r;
  logic [`AXI_DATA_WIDTH-1:0]     wdata_r;
  logic [`AXI_STROBE_WIDTH-1:0]   wstrb_r;
  logic [`AXI_DATA_WIDTH-1:0]     rsp_rdata_r;
  logic [`AXI_RESP_WIDTH-1:0]     rsp_resp_r;

  logic accept_s;
  logic aw_hs_s;
  logic w_hs_s;
  logic b_hs_s;
  logic ar_hs_s;
  logic r_hs_s;
  logic aw_fin_s;
  logic w_fin_s;

  assign accept_s = (state_r == ST_IDLE) && cmd_valid && cmd_ready_r;
  assign aw_hs_s  = awvalid_r && m_axi.awready;
  assign w_hs_s   = wvalid_r && m_axi.wready;
  assign b_hs_s   = bready_r && m_axi.bvalid;
  assign ar_hs_s  = arvalid_r && m_axi.arready;
  assign r_hs_s   = rready_r && m_axi.rvalid;
  // A channel counts as finished if it completed earlier or completes on this edge.
  assign aw_fin_s = aw_done_r || aw_hs_s;
  assign w_fin_s  = w_done_r || w_hs_s;

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt_r;
  logic             rsp_timeout_r;
  logic             axi_wait_s;
  logic             tmo_hit_s;

  assign axi_wait_s = (state_r == ST_WRITE) || (state_r == ST_WRESP) ||
                      (state_r == ST_RADDR) || (state_r == ST_RDATA);
  assign tmo_hit_s  = axi_wait_s && (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1));

  // Per-transaction cycle counter for the abort watchdog.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else if (accept_s) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else if (axi_wait_s) begin
      tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
    end
  end

  assign rsp_timeout = rsp_timeout_r;
`else
  assign rsp_timeout = 1'b0;
`endif

  // Command FSM; every bus and response output is a register driven from here.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_r     <= ST_IDLE;
      cmd_ready_r <= 1'b0;
      awvalid_r   <= 1'b0;
      wvalid_r    <= 1'b0;
      bready_r    <= 1'b0;
      arvalid_r   <= 1'b0;
      rready_r    <= 1'b0;
      aw_done_r   <= 1'b0;
      w_done_r    <= 1'b0;
      rsp_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      addr_r      <= {`AXI_ADDR_WIDTH{1'b0}};
      wdata_r     <= {`AXI_DATA_WIDTH{1'b0}};
      wstrb_r     <= {`AXI_STROBE_WIDTH{1'b0}};
      rsp_rdata_r <= {`AXI_DATA_WIDTH{1'b0}};
      rsp_resp_r  <= `AXI_RESP_OKAY;
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
      rsp_timeout_r <= 1'b0;
`endif
    end
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
    else if (tmo_hit_s) begin
      awvalid_r     <= 1'b0;
      wvalid_r      <= 1'b0;
      bready_r      <= 1'b0;
      arvalid_r     <= 1'b0;
      rready_r      <= 1'b0;
      rsp_valid_r   <= 1'b1;
      rsp_rdata_r   <= {`AXI_DATA_WIDTH{1'b0}};
      rsp_resp_r    <= `AXI_RESP_SLVERR;
      rsp_timeout_r <= 1'b1;
      state_r       <= ST_RESP;
    end
`endif
    else begin
      case (state_r)
        ST_IDLE: begin
          cmd_ready_r <= 1'b1;
          if (accept_s) begin
            cmd_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            addr_r      <= cmd_addr;
            wdata_r     <= cmd_wdata;
            wstrb_r     <= cmd_wstrb;
            aw_done_r   <= 1'b0;
            w_done_r    <= 1'b0;
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
            rsp_timeout_r <= 1'b0;
`endif
            if (cmd_write) begin
              awvalid_r <= 1'b1;
              wvalid_r  <= 1'b1;
              bready_r  <= 1'b1;
              state_r   <= ST_WRITE;
            end else begin
              arvalid_r <= 1'b1;
              state_r   <= ST_RADDR;
            end
          end
        end
        ST_WRITE: begin
          // B handshakes seen here precede AW/W completion and are dropped.
          if (aw_hs_s) begin
            awvalid_r <= 1'b0;
            aw_done_r <= 1'b1;
          end
          if (w_hs_s) begin
            wvalid_r <= 1'b0;
            w_done_r <= 1'b1;
          end
          if (aw_fin_s && w_fin_s) begin
            state_r <= ST_WRESP;
          end
        end
        ST_WRESP: begin
          if (b_hs_s) begin
            bready_r    <= 1'b0;
            rsp_valid_r <= 1'b1;
            rsp_rdata_r <= {`AXI_DATA_WIDTH{1'b0}};
            rsp_resp_r  <= m_axi.bresp;
            state_r     <= ST_RESP;
          end
        end
        ST_RADDR: begin
          if (ar_hs_s) begin
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
            state_r   <= ST_RDATA;
          end
        end
        ST_RDATA: begin
          if (r_hs_s) begin
            rready_r    <= 1'b0;
            rsp_valid_r <= 1'b1;
            rsp_rdata_r <= m_axi.rdata;
            rsp_resp_r  <= m_axi.rresp;
            state_r     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          awvalid_r   <= 1'b0;
          wvalid_r    <= 1'b0;
          bready_r    <= 1'b0;
          arvalid_r   <= 1'b0;
          rready_r    <= 1'b0;
          rsp_valid_r <= 1'b0;
          cmd_ready_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready     = cmd_ready_r;
  assign rsp_valid     = rsp_valid_r;
  assign rsp_rdata     = rsp_rdata_r;
  assign rsp_resp      = rsp_resp_r;
  assign busy          = busy_r;
  assign m_axi.awvalid = awvalid_r;
  assign m_axi.awaddr  = addr_r;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.wvalid  = wvalid_r;
  assign m_axi.wdata   = wdata_r;
  assign m_axi.wstrb   = wstrb_r;
  assign m_axi.bready  = bready_r;
  assign m_axi.arvalid = arvalid_r;
  assign m_axi.araddr  = addr_r;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.rready  = rready_r;

endmodule
